// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes and debounces three pushbuttons into one code with a one-cycle valid strobe.
// Define BTN_ENTRY_CNT_EN to add a 2-bit accepted-entry counter with a synchronous clear.
module btn_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] btn_raw,
`ifdef BTN_ENTRY_CNT_EN
    input  logic       entry_clr,
    output logic [1:0] entry_cnt,
`endif
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       code_valid,
    output logic       busy
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t                   state_q, state_d;
    logic [3*SYNC_STAGES-1:0] sync_q;
    logic [2:0]               cand_q, cand_d;
    logic [2:0]               code_q, code_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic                     busy_q;
    logic [2:0]               s;
    logic [CNT_W-1:0]         cnt_inc;

    // Last synchronizer stage is the only value the FSM ever looks at
    assign s       = sync_q[3*SYNC_STAGES-1 -: 3];
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s != 3'b000) begin
                    cand_d  = s;
                    cnt_d   = CNT_ONE;
                    state_d = DEBOUNCE;
                    if (CNT_ONE == CNT_MAX) begin
                        code_d  = s;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
            end
            DEBOUNCE: begin
                if (s == 3'b000) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (s != cand_q) begin
                    cand_d = s;
                    cnt_d  = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        code_d  = cand_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (s == 3'b000) begin
                    cnt_d   = CNT_ONE;
                    state_d = RELEASE;
                    if (CNT_ONE == CNT_MAX) begin
                        code_d  = 3'b000;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            RELEASE: begin
                if (s != 3'b000) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        code_d  = 3'b000;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[3*SYNC_STAGES-4:0], btn_raw};
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            busy_q  <= state_d != IDLE;
        end
    end

    assign {a, b, c}  = code_q;
    assign code_valid = valid_q;
    assign busy       = busy_q;

`ifdef BTN_ENTRY_CNT_EN
    logic [1:0] ecnt_q;

    // Counts strobes already presented; clear wins over a coincident increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ecnt_q <= '0;
        else          ecnt_q <= entry_clr ? 2'd0 : ecnt_q + {1'b0, valid_q};
    end

    assign entry_cnt = ecnt_q;
`endif
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: run-length reference model of the debouncer compared every cycle, plus directed timing checks.
module tb_btn_conditioner;
    localparam int SS = 2;
    localparam int DB = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] btn_raw = 3'b000;
    logic       entry_clr = 1'b0;
    logic       a, b, c, code_valid, busy;
`ifdef BTN_ENTRY_CNT_EN
    logic [1:0] entry_cnt;
`endif

    btn_conditioner #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
`ifdef BTN_ENTRY_CNT_EN
        .entry_clr(entry_clr),
        .entry_cnt(entry_cnt),
`endif
        .a(a),
        .b(b),
        .c(c),
        .code_valid(code_valid),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail = 0;
    int         edges = 0;
    int         nv = 0;
    int         v_edge = -1;
    int         fall_edge = -1;
    logic [2:0] v_code = 3'b000;
    logic [2:0] prev_abc = 3'b000;
    logic       prev_v = 1'b0;

    // Model: delay line for the synchronizer, then runs of identical samples decide accept/release
    typedef struct packed {
        logic [3*SS-1:0] hist;
        logic [2:0]      run_val;
        logic [7:0]      run_len;
        logic            locked;
        logic [2:0]      code;
        logic            valid;
        logic [1:0]      ecnt;
    } m_t;

    m_t m;

    function automatic m_t step(m_t o, logic [2:0] raw, logic clr);
        m_t         n = o;
        logic [2:0] s = o.hist[3*SS-1 -: 3];
        n.hist = {o.hist[3*SS-4:0], raw};
        if (s == o.run_val) n.run_len = (o.run_len == 8'hFF) ? o.run_len : o.run_len + 8'd1;
        else begin
            n.run_val = s;
            n.run_len = 8'd1;
        end
        n.valid = 1'b0;
        if (!o.locked && s != 3'b000 && n.run_len == 8'(DB)) begin
            n.code   = s;
            n.valid  = 1'b1;
            n.locked = 1'b1;
        end else if (o.locked && s == 3'b000 && n.run_len == 8'(DB)) begin
            n.code   = 3'b000;
            n.locked = 1'b0;
        end
        n.ecnt = clr ? 2'd0 : o.ecnt + {1'b0, o.valid};
        return n;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else          m <= step(m, btn_raw, entry_clr);
    end

    always @(posedge clock) edges <= edges + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, exp, edges);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            check("abc", {29'd0, a, b, c}, {29'd0, m.code});
            check("code_valid", {31'd0, code_valid}, {31'd0, m.valid});
            check("busy", {31'd0, busy}, {31'd0, m.locked || m.run_val != 3'b000});
            check("strobe_gap", {31'd0, prev_v & code_valid}, 32'd0);
`ifdef BTN_ENTRY_CNT_EN
            check("entry_cnt", {30'd0, entry_cnt}, {30'd0, m.ecnt});
`endif
            if (code_valid) begin
                nv++;
                v_edge = edges;
                v_code = {a, b, c};
            end
            if (prev_abc != 3'b000 && {a, b, c} == 3'b000) fall_edge = edges;
            prev_abc = {a, b, c};
            prev_v   = code_valid;
        end else begin
            prev_abc = 3'b000;
            prev_v   = 1'b0;
        end
    end

    task automatic drive(input logic [2:0] v, input int n, output int st);
        @(negedge clock);
        btn_raw = v;
        st = edges;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    initial begin
        int st, r0, n0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        wait_cycles(1);
        check("reset_abc", {29'd0, a, b, c}, 32'd0);
        check("reset_valid", {31'd0, code_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        n0 = nv;
        drive(3'b101, 12, st);
        drive(3'b000, 1, r0);
        wait_cycles(10);
        check("t1_strobes", nv - n0, 1);
        check("t1_latency", v_edge - st, 6);
        check("t1_code", {29'd0, v_code}, 32'd5);
        check("t1_release", fall_edge - r0, 6);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        n0 = nv;
        for (int i = 0; i < 6; i++) drive((i % 2 == 0) ? 3'b101 : 3'b000, 1, st);
        drive(3'b101, 10, st);
        drive(3'b000, 10, r0);
        check("t2_strobes", nv - n0, 1);
        check("t2_latency", v_edge - st, 6);
        check("t2_code", {29'd0, v_code}, 32'd5);

        n0 = nv;
        drive(3'b100, 2, st);
        drive(3'b110, 10, st);
        drive(3'b000, 10, r0);
        check("t3_strobes", nv - n0, 1);
        check("t3_latency", v_edge - st, 6);
        check("t3_code", {29'd0, v_code}, 32'd6);

        n0 = nv;
        drive(3'b101, 10, st);
        drive(3'b111, 8, r0);
        #1;
        check("t4_held", {29'd0, a, b, c}, 32'd5);
        drive(3'b000, 1, r0);
        wait_cycles(10);
        check("t4_strobes", nv - n0, 1);
        check("t4_release", fall_edge - r0, 6);

        n0 = nv;
        drive(3'b101, 4, st);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("t5_abc_in_reset", {29'd0, a, b, c}, 32'd0);
        check("t5_valid_in_reset", {31'd0, code_valid}, 32'd0);
        check("t5_busy_in_reset", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        r0 = edges;
        check("t5_no_strobe", nv - n0, 0);
        wait_cycles(10);
        check("t5_strobes", nv - n0, 1);
        check("t5_latency", v_edge - r0, 6);
        drive(3'b000, 10, r0);

`ifdef BTN_ENTRY_CNT_EN
        @(negedge clock);
        entry_clr = 1'b1;
        @(negedge clock);
        entry_clr = 1'b0;
        #1;
        check("t6_cleared", {30'd0, entry_cnt}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(3'b011, 10, st);
            drive(3'b000, 10, r0);
            check("t6_cnt", {30'd0, entry_cnt}, k % 4);
        end
        drive(3'b011, 1, st);
        for (int i = 0; i < 20 && !code_valid; i++) @(negedge clock);
        check("t6_strobe_seen", {31'd0, code_valid}, 32'd1);
        entry_clr = 1'b1;
        @(negedge clock);
        entry_clr = 1'b0;
        #1;
        check("t6_clr_priority", {30'd0, entry_cnt}, 32'd0);
        drive(3'b000, 10, r0);
`endif

        for (int i = 0; i < 150; i++) begin
            logic [2:0] v;
            v = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            drive(v, $urandom_range(1, 8), st);
        end
        drive(3'b000, 12, r0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage that sits directly upstream of the combination-lock FSM and drives its a/b/c inputs.
- Synchronizes three raw, bouncing pushbuttons to `clock` and debounces them as one 3-bit code.
- Presents each accepted code to the lock FSM as stable levels, with a one-cycle `code_valid` strobe.
- Each physical press produces exactly one code; a new code requires a debounced full release first.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per button (legal: ≥2).
- DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples needed to accept a press or a release (legal: ≥1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), localparam; width of the debounce counter.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_raw  input  3  raw buttons, asynchronous; [2]=a, [1]=b, [0]=c; 1 = pressed.
- a  output  1  accepted code bit a, to lock FSM.
- b  output  1  accepted code bit b, to lock FSM.
- c  output  1  accepted code bit c, to lock FSM.
- code_valid  output  1  one-cycle pulse when a new code is accepted.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (reset_n=0, async):
  - Sync flops, cand, cnt and a/b/c/code_valid all cleared to 0.
  - State = IDLE; busy = 0.
  - Reset mid-operation discards any partial press; no strobe is generated.
- Sample s = output of the last sync stage. Edge 1 is the first edge that captures a new btn_raw value; s reflects it after edge SYNC_STAGES.
- Registers: cand[2:0] is the candidate code; cnt[CNT_W-1:0] counts consecutive matching samples.
- IDLE:
  - s==000: stay.
  - s≠000: cand<=s, cnt<=1, go DEBOUNCE.
  - If DEBOUNCE_CYCLES==1, accept immediately (see accept).
- DEBOUNCE:
  - s==000: go IDLE, cnt<=0.
  - s≠cand (nonzero): cand<=s, cnt<=1 (restart).
  - s==cand: cnt<=cnt+1; when cnt+1==DEBOUNCE_CYCLES, accept.
- Accept (registered, on that same edge):
  - {a,b,c}<=cand; code_valid<=1 for exactly one cycle; go HELD.
  - With defaults, code_valid is high after edge SYNC_STAGES+DEBOUNCE_CYCLES = 6 when the input is clean.
- HELD:
  - Any nonzero s, including a different code, is ignored; a/b/c hold the accepted code.
  - s==000: cnt<=1, go RELEASE. If DEBOUNCE_CYCLES==1, release immediately (see below).
- RELEASE:
  - s≠000: cnt<=0, go HELD; outputs unchanged.
  - s==000: cnt<=cnt+1; when the count reaches DEBOUNCE_CYCLES, {a,b,c}<=000 and go IDLE.
- code_valid is never high on two consecutive cycles; it is 0 in every state other than the accept edge.
- Counter saturation cannot occur: cnt is cleared or restarted before it exceeds DEBOUNCE_CYCLES.
- busy = (state≠IDLE), registered decode.

Optional Feature:
- Macro: BTN_ENTRY_CNT_EN.
- Defined:
  - Adds input entry_clr (1b, synchronous clear) and output entry_cnt (2b, reset 0).
  - entry_cnt increments on every code_valid and wraps 3→0.
  - entry_clr has priority over a simultaneous increment, giving 0.
- Undefined: both ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
1. Clean press: btn_raw=101 from edge 1, held 12 cycles, then 000 → single code_valid after edge 6; a,b,c=1,0,1 until 4 consecutive zero samples, then 000 after edge 6 counted from the release; busy 0 afterwards.
2. Bounce: btn_raw alternates 101/000 each cycle for 6 cycles, then stable 101 → exactly one code_valid, asserted 6 edges after the stable value starts; a,b,c=101.
3. Change during debounce: 100 for 2 cycles, then 110 held → cand restarts; exactly one code_valid, with a,b,c=110; code 100 is never output.
4. Change while held: after 101 is accepted, btn_raw→111 for 8 cycles, then 000 → no second code_valid; a,b,c stay 101 until release completes.
5. Reset mid-debounce: 101 for 4 cycles (not yet accepted), pulse reset_n low for 1 cycle asynchronously mid-cycle, keep 101 → outputs 000 immediately; no strobe; accept occurs 6 edges after reset deassertion.
6. (BTN_ENTRY_CNT_EN) Four clean presses → entry_cnt 1,2,3,0; fifth press with entry_clr=1 on its code_valid cycle → entry_cnt=0.
